// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status encoding and
// the default register ids for the stack pointer and the RNONE slot.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_ERR  = 2'd2
  } stat_t;

  localparam int RSP   = 4;
  localparam int RNONE = 15;

endpackage

// File: rtl/wb_dst_decode.sv
// Combinational destination decode: icode/cnd/rA/rB -> dstE/dstM.
// Ports: icode, cnd, rA, rB in; dstE, dstM out (RNONE = no write).
module wb_dst_decode
  import y86_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int RSP_ID = RSP,
  parameter int RW     = $clog2(NREG)
) (
  input  logic [3:0]    icode,
  input  logic          cnd,
  input  logic [RW-1:0] rA,
  input  logic [RW-1:0] rB,
  output logic [RW-1:0] dstE,
  output logic [RW-1:0] dstM
);

  localparam logic [RW-1:0] RNone = RW'(NREG - 1);
  localparam logic [RW-1:0] RspId = RW'(RSP_ID);

  always_comb begin
    dstE = RNone;
    dstM = RNone;
    unique case (1'b1)
      (icode == I_CMOV):  dstE = cnd ? rB : RNone;
      (icode == I_IRMOV): dstE = rB;
      (icode == I_MRMOV): dstM = rA;
      (icode == I_OP):    dstE = rB;
      (icode == I_CALL),
      (icode == I_RET),
      (icode == I_PUSH):  dstE = RspId;
      (icode == I_POP): begin
        dstE = RspId;
        dstM = rA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage + register file: commits valE/valM, tracks stat, counts retires.
// Ports: clk, rst_n, wb_valid, wb_stall, icode, cnd, rA, rB, valE, valM,
// srcA/srcB -> rd_a/rd_b, dstE, dstM, stat, retire_cnt.
// Option: define WB_BYPASS_EN to forward this cycle's commit onto the read ports.
module wb_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 16,
  parameter int RSP_ID = RSP,
  parameter int CNT_W  = 32,
  parameter int RW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic              wb_stall,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [RW-1:0]     rA,
  input  logic [RW-1:0]     rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [RW-1:0]     srcA,
  input  logic [RW-1:0]     srcB,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [RW-1:0]     dstE,
  output logic [RW-1:0]     dstM,
  output logic [1:0]        stat,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [RW-1:0] RNone = RW'(NREG - 1);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cntQ;
  stat_t             stateQ, stateD;

  logic commit, isHalt, isBad, writeEn, countEn;

  wb_dst_decode #(
    .NREG   (NREG),
    .RSP_ID (RSP_ID),
    .RW     (RW)
  ) uDec (
    .icode (icode),
    .cnd   (cnd),
    .rA    (rA),
    .rB    (rB),
    .dstE  (dstE),
    .dstM  (dstM)
  );

  assign commit  = (stateQ == S_RUN) && wb_valid && !wb_stall;
  assign isHalt  = (icode == I_HALT);
  assign isBad   = (icode > I_POP);
  assign writeEn = commit && !isHalt && !isBad;
  assign countEn = commit && !isBad && (cntQ != '1);

  always_comb begin
    stateD = stateQ;
    if (commit) begin
      unique case (1'b1)
        isHalt:  stateD = S_HALT;
        isBad:   stateD = S_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= S_RUN;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      if (countEn) cntQ <= cntQ + 1'b1;
    end
  end

  // The M write is issued last so it overrides E when both target one reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (writeEn) begin
      if (dstE != RNone) regs[dstE] <= valE;
      if (dstM != RNone) regs[dstM] <= valM;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(
    input logic [RW-1:0] src
  );
    logic [DATA_W-1:0] v;
    v = (src == RNone) ? '0 : regs[src];
`ifdef WB_BYPASS_EN
    if (writeEn && src != RNone) begin
      unique case (1'b1)
        (src == dstM): v = valM;
        (src == dstE): v = valE;
        default: ;
      endcase
    end
`endif
    return v;
  endfunction

  assign rd_a       = readPort(srcA);
  assign rd_b       = readPort(srcB);
  assign stat       = stateQ;
  assign retire_cnt = cntQ;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random
// traffic against a spec-level model of registers, status and counter.
module tb_wb_regfile;
  import y86_pkg::*;

  localparam int DW = 64;
  localparam int NR = 16;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_stall = 1'b0;
  logic [3:0]    icode = 4'h1;
  logic          cnd = 1'b0;
  logic [RW-1:0] rA = '0, rB = '0, srcA = '0, srcB = '0;
  logic [DW-1:0] valE = '0, valM = '0;
  logic [DW-1:0] rd_a, rd_b;
  logic [RW-1:0] dstE, dstM;
  logic [1:0]    stat;
  logic [CW-1:0] retire_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mReg [NR];
  int mStat;
  int mCnt;

  wb_regfile #(
    .DATA_W (DW),
    .NREG   (NR),
    .RSP_ID (4),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_stall   (wb_stall),
    .icode      (icode),
    .cnd        (cnd),
    .rA         (rA),
    .rB         (rB),
    .valE       (valE),
    .valM       (valM),
    .srcA       (srcA),
    .srcB       (srcB),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .dstE       (dstE),
    .dstM       (dstM),
    .stat       (stat),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic int expE(input int ic, input bit c, input int a, input int b);
    case (ic)
      2:            return c ? b : 15;
      3, 6:         return b;
      8, 9, 10, 11: return 4;
      default:      return 15;
    endcase
  endfunction

  function automatic int expM(input int ic, input int a);
    if (ic == 5 || ic == 11) return a;
    return 15;
  endfunction

  function automatic logic [DW-1:0] expRd(input int src);
    if (src == 15) return '0;
`ifdef WB_BYPASS_EN
    if (mStat == 0 && wb_valid && !wb_stall && icode >= 1 && icode <= 11) begin
      if (expM(int'(icode), int'(rA)) == src) return valM;
      if (expE(int'(icode), cnd, int'(rA), int'(rB)) == src) return valE;
    end
`endif
    return mReg[src];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NR; i++) mReg[i] = '0;
    mStat = 0;
    mCnt = 0;
  endtask

  task automatic modelCommit();
    int e, m;
    if (mStat == 0 && wb_valid && !wb_stall) begin
      if (icode == 0) begin
        mStat = 1;
        if (mCnt < CMAX) mCnt++;
      end else if (icode > 11) begin
        mStat = 2;
      end else begin
        e = expE(int'(icode), cnd, int'(rA), int'(rB));
        m = expM(int'(icode), int'(rA));
        if (e != 15) mReg[e] = valE;
        if (m != 15) mReg[m] = valM;
        if (mCnt < CMAX) mCnt++;
      end
    end
  endtask

  task automatic tick();
    modelCommit();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    wb_valid = 1'b0;
    wb_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ic, input int a, input int b,
                       input logic [DW-1:0] e, input logic [DW-1:0] m);
    icode = 4'(ic);
    rA = RW'(a);
    rB = RW'(b);
    valE = e;
    valM = m;
    wb_valid = 1'b1;
    wb_stall = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (stat !== 2'd0) begin
      failures++;
      $display("FAIL reset_stat got=%0d want=0", stat);
    end
    checks++;
    if (retire_cnt !== '0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d want=0", retire_cnt);
    end
    for (int i = 0; i < NR; i++) begin
      srcA = RW'(i);
      #1;
      checks++;
      if (rd_a !== '0) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h want=0", i, rd_a);
      end
    end
  endtask

  task automatic test_irmov();
    doReset();
    drive(3, 15, 2, 64'h1234, 64'h0);
    #1;
    checks++;
    if (dstE !== 4'd2 || dstM !== 4'd15) begin
      failures++;
      $display("FAIL irmov_dst got=%0d/%0d want=2/15", dstE, dstM);
    end
    tick();
    wb_valid = 1'b0;
    srcA = 4'd2;
    #1;
    checks++;
    if (rd_a !== 64'h1234) begin
      failures++;
      $display("FAIL irmov_reg2 got=%h want=1234", rd_a);
    end
    checks++;
    if (retire_cnt !== 4'd1) begin
      failures++;
      $display("FAIL irmov_cnt got=%0d want=1", retire_cnt);
    end
  endtask

  task automatic test_cmov();
    doReset();
    drive(2, 15, 3, 64'hAA, 64'h0);
    cnd = 1'b0;
    #1;
    checks++;
    if (dstE !== 4'd15) begin
      failures++;
      $display("FAIL cmov_dst_nc got=%0d want=15", dstE);
    end
    tick();
    srcA = 4'd3;
    wb_valid = 1'b0;
    #1;
    checks++;
    if (rd_a !== 64'h0 || retire_cnt !== 4'd1) begin
      failures++;
      $display("FAIL cmov_nc got=%h/%0d want=0/1", rd_a, retire_cnt);
    end
    wb_valid = 1'b1;
    cnd = 1'b1;
    tick();
    wb_valid = 1'b0;
    cnd = 1'b0;
    #1;
    checks++;
    if (rd_a !== 64'hAA || retire_cnt !== 4'd2) begin
      failures++;
      $display("FAIL cmov_c got=%h/%0d want=aa/2", rd_a, retire_cnt);
    end
  endtask

  task automatic test_pop();
    doReset();
    drive(11, 4, 15, 64'h108, 64'h55);
    tick();
    wb_valid = 1'b0;
    srcA = 4'd4;
    #1;
    checks++;
    if (rd_a !== 64'h55) begin
      failures++;
      $display("FAIL pop_rsp got=%h want=55", rd_a);
    end
    drive(11, 1, 15, 64'h108, 64'h55);
    tick();
    wb_valid = 1'b0;
    srcA = 4'd4;
    srcB = 4'd1;
    #1;
    checks++;
    if (rd_a !== 64'h108 || rd_b !== 64'h55) begin
      failures++;
      $display("FAIL pop_r1 got=%h/%h want=108/55", rd_a, rd_b);
    end
  endtask

  task automatic test_halt();
    doReset();
    drive(3, 15, 2, 64'h9, 64'h0);
    tick();
    drive(0, 15, 15, 64'h0, 64'h0);
    tick();
    checks++;
    if (stat !== 2'd1 || retire_cnt !== 4'd2) begin
      failures++;
      $display("FAIL halt got=%0d/%0d want=1/2", stat, retire_cnt);
    end
    drive(3, 15, 5, 64'h7, 64'h0);
    tick();
    wb_valid = 1'b0;
    srcA = 4'd5;
    srcB = 4'd2;
    #1;
    checks++;
    if (rd_a !== 64'h0 || retire_cnt !== 4'd2 || stat !== 2'd1) begin
      failures++;
      $display("FAIL halt_ignore got=%h/%0d/%0d want=0/2/1", rd_a, retire_cnt, stat);
    end
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checks++;
    if (stat !== 2'd0 || retire_cnt !== '0 || rd_b !== '0) begin
      failures++;
      $display("FAIL midrst got=%0d/%0d/%h want=0/0/0", stat, retire_cnt, rd_b);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(3, 15, 6, 64'h33, 64'h0);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wb_valid = 1'b0;
    srcA = 4'd6;
    #1;
    checks++;
    if (rd_a !== '0 || retire_cnt !== '0) begin
      failures++;
      $display("FAIL rst_abort got=%h/%0d want=0/0", rd_a, retire_cnt);
    end
  endtask

  task automatic test_err_stall();
    doReset();
    drive(15, 15, 2, 64'h5, 64'h6);
    tick();
    wb_valid = 1'b0;
    srcA = 4'd2;
    #1;
    checks++;
    if (stat !== 2'd2 || rd_a !== '0 || retire_cnt !== '0) begin
      failures++;
      $display("FAIL err got=%0d/%h/%0d want=2/0/0", stat, rd_a, retire_cnt);
    end
    doReset();
    drive(6, 15, 6, 64'h9, 64'h0);
    wb_stall = 1'b1;
    tick();
    srcA = 4'd6;
    #1;
    checks++;
    if (rd_a !== '0 || retire_cnt !== '0 || dstE !== 4'd6) begin
      failures++;
      $display("FAIL stall got=%h/%0d/%0d want=0/0/6", rd_a, retire_cnt, dstE);
    end
    wb_stall = 1'b0;
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (rd_a !== 64'h9) begin
      failures++;
      $display("FAIL unstall got=%h want=9", rd_a);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    doReset();
    drive(5, 7, 15, 64'h0, 64'h77);
    srcB = 4'd7;
    #1;
`ifdef WB_BYPASS_EN
    want = 64'h77;
`else
    want = 64'h0;
`endif
    checks++;
    if (rd_b !== want) begin
      failures++;
      $display("FAIL bypass_pre got=%h want=%h", rd_b, want);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (rd_b !== 64'h77) begin
      failures++;
      $display("FAIL bypass_post got=%h want=77", rd_b);
    end
  endtask

  task automatic test_saturate();
    doReset();
    drive(1, 15, 15, 64'h0, 64'h0);
    for (int i = 0; i < CMAX + 3; i++) tick();
    checks++;
    if (retire_cnt !== CW'(CMAX) || stat !== 2'd0) begin
      failures++;
      $display("FAIL saturate got=%0d/%0d want=%0d/0", retire_cnt, stat, CMAX);
    end
  endtask

  task automatic test_random();
    int ic;
    int e, m;
    logic [DW-1:0] wa, wb;
    doReset();
    for (int n = 0; n < 400; n++) begin
      if (mStat != 0 && $urandom_range(0, 3) == 0) doReset();
      if (mCnt == CMAX && $urandom_range(0, 7) == 0) doReset();
      ic = ($urandom_range(0, 29) == 0) ? $urandom_range(12, 15) :
           ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 11);
      drive(ic, $urandom_range(0, 15), $urandom_range(0, 15),
            {$urandom, $urandom}, {$urandom, $urandom});
      cnd = 1'($urandom_range(0, 1));
      wb_valid = ($urandom_range(0, 4) != 0);
      wb_stall = ($urandom_range(0, 4) == 0);
      srcA = RW'($urandom_range(0, 15));
      srcB = RW'($urandom_range(0, 15));
      #1;
      e = expE(ic, cnd, int'(rA), int'(rB));
      m = expM(ic, int'(rA));
      wa = expRd(int'(srcA));
      wb = expRd(int'(srcB));
      checks++;
      if (dstE !== RW'(e) || dstM !== RW'(m)) begin
        failures++;
        $display("FAIL rnd_dst n=%0d ic=%0d got=%0d/%0d want=%0d/%0d", n, ic, dstE, dstM, e, m);
      end
      checks++;
      if (rd_a !== wa || rd_b !== wb) begin
        failures++;
        $display("FAIL rnd_rd n=%0d got=%h/%h want=%h/%h", n, rd_a, rd_b, wa, wb);
      end
      tick();
      checks++;
      if (stat !== 2'(mStat) || retire_cnt !== CW'(mCnt)) begin
        failures++;
        $display("FAIL rnd_state n=%0d got=%0d/%0d want=%0d/%0d", n, stat, retire_cnt, mStat, mCnt);
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_irmov();
    test_cmov();
    test_pop();
    test_halt();
    test_err_stall();
    test_bypass();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Parametrised write-back stage merged with the architectural register file for the Y86-64 SEQ core.
- Decodes icode/cnd into the dstE/dstM destinations and commits valE/valM on the clock edge.
- Serves two combinational read ports to decode.
- Tracks processor status (RUN/HALT/ERR) and counts retired instructions.

Parameters:
- DATA_W, 64, register width in bits.
- NREG, 16, register count including the RNONE slot; register id width is $clog2(NREG).
- RSP_ID, 4, index of the stack pointer.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  current instruction is valid for write-back.
- wb_stall  in  1  hold; no commit this cycle.
- icode  in  4  instruction code.
- cnd  in  1  condition result; gates cmovXX.
- rA  in  RW  register field A.
- rB  in  RW  register field B.
- valE  in  DATA_W  ALU result.
- valM  in  DATA_W  memory read data.
- srcA  in  RW  read port A address.
- srcB  in  RW  read port B address.
- rd_a  out  DATA_W  read port A data.
- rd_b  out  DATA_W  read port B data.
- dstE  out  RW  decoded E destination, combinational.
- dstM  out  RW  decoded M destination, combinational.
- stat  out  2  0=RUN, 1=HALT, 2=ERR.
- retire_cnt  out  CNT_W  instructions committed.

RW = $clog2(NREG); RNONE = NREG-1.

Behaviour:
- Reset (async, rst_n=0): every register is 0, stat=RUN, retire_cnt=0. Reset asserted mid-cycle aborts any pending commit.
- Destination decode (combinational). Anything not listed gives dstE=dstM=RNONE.
  - 2 cmovXX: dstE = cnd ? rB : RNONE.
  - 3 irmovq: dstE = rB.
  - 5 mrmovq: dstM = rA.
  - 6 OPq: dstE = rB.
  - 8 call, 9 ret, A pushq: dstE = RSP_ID.
  - B popq: dstE = RSP_ID, dstM = rA.
- Commit fires when stat==RUN && wb_valid && !wb_stall, at the next rising edge (1-cycle latency):
  - reg[dstE] <= valE and reg[dstM] <= valM.
  - If dstE==dstM, valM wins (popq %rsp loads the popped value).
  - Writes to RNONE are discarded.
  - retire_cnt increments by one, saturating at all-ones.
- Status FSM:
  - RUN → HALT on commit with icode 0 (halt). That commit does no register writes but is counted.
  - RUN → ERR on commit with icode > 0xB. No writes, not counted.
  - HALT and ERR are absorbing until reset; all later commits are ignored.
- wb_stall=1 or wb_valid=0: no state change. dstE/dstM still reflect the inputs.
- Read ports are combinational from the array. Reading RNONE returns 0. Without bypass, a read in the same cycle as a commit to that register returns the old value.

Optional Feature:
- WB_BYPASS_EN defined: rd_a/rd_b forward the value being committed this cycle when the address matches a live dstE/dstM. Priority is valM over valE over the array; RNONE is never forwarded.
- Undefined: pure array read, as above.

Decomposition:
- Package y86_pkg holds:
  - icode localparams (I_HALT, I_NOP, I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OP, I_JXX, I_CALL, I_RET, I_PUSH, I_POP).
  - stat_t enum (RUN/HALT/ERR).
  - RSP and RNONE constants.
- One sub-module, wb_dst_decode: purely combinational icode/cnd/rA/rB → dstE/dstM. It is reused by the future pipelined decode stage.

Test Plan:
- Commit irmovq (icode=3, rB=2, valE=0x1234) → after one edge, srcA=2 gives rd_a=0x1234 and retire_cnt=1.
- cmov icode=2, rB=3, valE=0xAA: with cnd=0, reg3 stays 0; with cnd=1, reg3=0xAA and retire_cnt advances on both.
- popq icode=B with rA=RSP_ID=4, valE=0x108, valM=0x55 → reg4=0x55. Then popq with rA=1 → reg4=0x108, reg1=0x55.
- icode=0 commit → stat=HALT. A subsequent irmovq (rB=5, valE=7) leaves reg5=0 and retire_cnt unchanged. Pulsing rst_n=0 mid-cycle returns stat=RUN and clears all registers and the counter.
- icode=0xF → stat=ERR with no write. Separately, wb_stall=1 with a valid OPq (rB=6, valE=9) leaves reg6 unchanged.
- With WB_BYPASS_EN, mrmovq rA=7, valM=0x77 and srcB=7 in the commit cycle → rd_b=0x77 before the edge. Without it, rd_b=0 in that cycle.
